// File: rtl/apb3_arb_pkg.sv
// Shared definitions for the APB3 request arbiter: FSM encoding, clog2 helper, default timeout.
package apb3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb3_rr_grant.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping around.
module apb3_rr_grant
    import apb3_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/apb3_req_arbiter.sv
// Round-robin sharing of one APB3 master port between NUM_REQ requesters, with ACCESS timeout.
// IDLE: arbitrate, respond | SETUP: PSEL only | ACCESS: PENABLE, wait PREADY or timeout
module apb3_req_arbiter
    import apb3_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                          HCLK,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int IW = clog2(NUM_REQ);
    localparam int CW = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    // Count of earlier PREADY-low cycles that makes the current low cycle the last allowed one.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IW-1:0]      gnt_idx;

    apb3_rr_grant #(.NUM_REQ(NUM_REQ), .IDX_W(IW)) u_grant (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt_onehot),
        .idx   (gnt_idx)
    );

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            cnt       <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        ptr       <= gnt_idx;
                        PADDR     <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        PWDATA    <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        PWRITE    <= req_write[gnt_idx];
                        req_ready <= gnt_onehot;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << ptr;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        state     <= IDLE;
                    end else begin
                        if (cnt != '1) cnt <= cnt + 1'b1;
                        if (TO_EN && cnt == CNT_LAST) begin
                            PSEL      <= 1'b0;
                            PENABLE   <= 1'b0;
                            rsp_valid <= NUM_REQ'(1) << ptr;
                            rsp_err   <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb3_req_arbiter.md
Name: apb3_req_arbiter

Overview:
Shares one APB3 master port between NUM_REQ local requesters using round-robin arbitration.
Sequences each granted request through the APB3 SETUP and ACCESS phases, driving PSEL and PENABLE directly.
Captures PRDATA/PSLVERR and returns a one-cycle response to the owning requester.
Forces completion with an error response if a slave holds PREADY low beyond a programmable timeout.
Sits between bridge-side control logic and the APB3 slave fabric in the HCLK domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 20, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width
TIMEOUT, 255, maximum ACCESS cycles with PREADY low before forced error; 0 disables the timeout

Ports:
HCLK  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request; held with payload until req_ready
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transfer complete
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer): state=IDLE and every output=0; the round-robin pointer is set to NUM_REQ-1 so requester 0 wins first. An in-flight transfer is dropped without a response.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS.
- IDLE with no req_valid: stay in IDLE.
- IDLE with any req_valid: the round-robin grant searches from ptr+1 upward with wrap-around. At the edge:
  - ptr is set to the grant index.
  - addr, write and wdata are latched into PADDR/PWRITE/PWDATA.
  - state becomes SETUP with PSEL=1, PENABLE=0.
  - req_ready[grant] is asserted for exactly one cycle.
- SETUP: unconditionally go to ACCESS with PENABLE=1. The timeout counter is cleared.
- ACCESS with PREADY=1: at the edge go to IDLE with PSEL=0 and PENABLE=0. In the same cycle rsp_valid[grant]=1, rsp_rdata=PRDATA (0 for writes) and rsp_err=PSLVERR.
- ACCESS with PREADY=0: the counter increments.
  - If TIMEOUT!=0 and this is the TIMEOUT-th such cycle: go to IDLE, PSEL=PENABLE=0, rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0.
  - PREADY=1 in that same cycle wins and the transfer completes normally.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle. Their values are held, not cleared, in IDLE.
- Minimum transfer: 1 SETUP cycle + 1 ACCESS cycle + 1 IDLE cycle, so back-to-back transfers take 3 cycles each.
- req_valid changes during SETUP/ACCESS are ignored.
- A requester that drops req_valid before req_ready is simply not granted. There is no error.
- Simultaneous requests: exactly one grant per arbitration. The just-served requester has the lowest priority next time.
- rsp_rdata and rsp_err are don't-care when no rsp_valid bit is set. They are held at 0 except in the response cycle.
- Timeout counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.

Decomposition:
- Package apb3_arb_pkg holds:
  - state encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10)
  - a clog2 function
  - a default TIMEOUT constant
- One sub-module, apb3_rr_grant. It is combinational: inputs req vector and ptr; outputs one-hot grant and index. It is reused by the top and checked standalone.

Test Plan:
- Single read, req 2, addr 0x00010, PREADY high first ACCESS cycle, PRDATA=0xDEADBEEF -> req_ready[2] with PSEL rise; PENABLE high 1 cycle; rsp_valid[2] pulse with rsp_rdata=0xDEADBEEF, rsp_err=0; 3-cycle period.
- All 4 requesters valid continuously -> grants in order 0,1,2,3,0; no requester served twice before the others.
- Write to req 1 with PREADY low 3 cycles, PSLVERR=1 on completion -> PENABLE high 4 cycles; PADDR/PWDATA stable; rsp_valid[1] with rsp_err=1.
- TIMEOUT=4, PREADY held low -> forced completion after 4 ACCESS cycles; rsp_err=1, rsp_rdata=0. Repeat with PREADY rising on cycle 4 -> normal response.
- aresetn asserted during ACCESS -> PSEL, PENABLE, req_ready and rsp_valid go to 0 immediately; no response; after release, requester 0 is granted first.
- req 3 pulses req_valid for 1 cycle while a transfer is in progress, then drops it -> no grant and no response for requester 3.
